// File: rtl/counter_sched.sv
// Round-robin scheduler owning one WIDTH-bit up-counter shared by N requesters.
// Handshake: req is a level held by a requester until it sees done or aborted; grant shows the owner.
module counter_sched #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] len,
    output logic [N-1:0]       grant,
    output logic               busy,
    output logic               cnt_en,
    output logic [WIDTH-1:0]   count,
    output logic [N-1:0]       done,
    output logic [N-1:0]       aborted,
    output logic [1:0]         state_dbg
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [N-1:0]     done_q, done_d;
    logic [N-1:0]     aborted_q, aborted_d;

    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [WIDTH-1:0] win_len;

    // Search upward from ptr+1 so the last owner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_len   = '0;
        for (int i = 0; i < N; i++) begin
            if (!win_found && req[(int'(ptr_q) + 1 + i) % N]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(ptr_q) + 1 + i) % N);
                win_len   = len[((int'(ptr_q) + 1 + i) % N) * WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        count_d   = count_q;
        tc_d      = tc_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        done_d    = '0;
        aborted_d = '0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                grant_d = '0;
                if (win_found) begin
                    owner_d = win_idx;
                    tc_d    = win_len;
                    grant_d = N'(1) << win_idx;
                    if (win_len != '0) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                        done_d  = N'(1) << win_idx;
                    end
                end
            end
            RUN: begin
                // A dropped request wins over a terminal count in the same cycle.
                if (!req[owner_q]) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    count_d   = '0;
                    ptr_d     = owner_q;
                    aborted_d = grant_q;
                end else if (count_q == tc_q - WIDTH'(1)) begin
                    state_d = DONE;
                    count_d = tc_q;
                    done_d  = grant_q;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
                ptr_d   = owner_q;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            count_q   <= '0;
            tc_q      <= '0;
            ptr_q     <= PW'(N - 1);
            owner_q   <= '0;
            done_q    <= '0;
            aborted_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            count_q   <= count_d;
            tc_q      <= tc_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign cnt_en    = (state_q == RUN);
    assign count     = count_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign state_dbg = state_q;

endmodule
